// File: rtl/ysyx_22050243_rr_encoder_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22050243_rr_encoder_pkg
// Shared constants for the round-robin encoder slice: default request count,
// default index width and the two-state handshake FSM encoding.
// No ports.
// ---------------------------------------------------------------------------
package ysyx_22050243_rr_encoder_pkg;

  localparam int DEFAULT_NR_REQ  = 8;
  localparam int DEFAULT_IDX_LEN = 3;

  // EMPTY: no grant held (out_valid=0); FULL: a grant waits for the consumer.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/ysyx_22050243_rr_encoder_if.sv
// ---------------------------------------------------------------------------
// ysyx_22050243_rr_encoder_if
// Request / grant bundle between the requesters+consumer and the encoder.
//   req        : level request vector, bit i = requester i pending
//   out_ready  : consumer accepts the current grant
//   out_valid  : a grant is held in out_idx/out_onehot
//   out_idx    : binary index of the granted requester
//   out_onehot : one-hot of out_idx, zero when out_valid=0
// modport master : environment side (drives req/out_ready)
// modport slave  : encoder side (drives the grant outputs)
// ---------------------------------------------------------------------------
interface ysyx_22050243_rr_encoder_if
  import ysyx_22050243_rr_encoder_pkg::*;
#(
  parameter int NR_REQ  = DEFAULT_NR_REQ,
  parameter int IDX_LEN = DEFAULT_IDX_LEN
);

  logic [NR_REQ-1:0]  req;
  logic               out_ready;
  logic               out_valid;
  logic [IDX_LEN-1:0] out_idx;
  logic [NR_REQ-1:0]  out_onehot;

  modport master (
    output req, out_ready,
    input  out_valid, out_idx, out_onehot
  );

  modport slave (
    input  req, out_ready,
    output out_valid, out_idx, out_onehot
  );

endinterface

// File: rtl/ysyx_22050243_rr_encoder_prienc.sv
// ---------------------------------------------------------------------------
// ysyx_22050243_prienc
// Combinational fixed-priority encoder, lowest set index wins.
//   req    : input request vector
//   hit    : any bit of req set
//   idx    : index of the lowest set bit (0 when no hit)
//   onehot : one-hot of idx (zero when no hit)
// ---------------------------------------------------------------------------
module ysyx_22050243_prienc
  import ysyx_22050243_rr_encoder_pkg::*;
#(
  parameter int NR_REQ  = DEFAULT_NR_REQ,
  parameter int IDX_LEN = DEFAULT_IDX_LEN
) (
  input  logic [NR_REQ-1:0]  req,
  output logic               hit,
  output logic [IDX_LEN-1:0] idx,
  output logic [NR_REQ-1:0]  onehot
);

  // Scanning from the top down lets the lowest set bit overwrite the others.
  always_comb begin
    hit    = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int i = NR_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        hit       = 1'b1;
        idx       = IDX_LEN'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ysyx_22050243_rr_encoder.sv
// ---------------------------------------------------------------------------
// ysyx_22050243_rr_encoder
// Registered round-robin priority encoder with a valid/ready output.
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset
//   bus : slave modport of ysyx_22050243_rr_encoder_if (req, out_ready in;
//         out_valid, out_idx, out_onehot out)
// A rotating pointer sets the scan start; the scan wraps at NR_REQ.
// ---------------------------------------------------------------------------
module ysyx_22050243_rr_encoder
  import ysyx_22050243_rr_encoder_pkg::*;
#(
  parameter int NR_REQ  = DEFAULT_NR_REQ,
  parameter int IDX_LEN = DEFAULT_IDX_LEN
) (
  input  logic                        clk,
  input  logic                        rst,
  ysyx_22050243_rr_encoder_if.slave   bus
);

  state_t             state;
  state_t             state_next;
  logic [IDX_LEN-1:0] ptr;
  logic [IDX_LEN-1:0] idx_q;
  logic [NR_REQ-1:0]  onehot_q;

  logic               handshake;
  logic               load;
  logic [NR_REQ-1:0]  eligible;
  logic [NR_REQ-1:0]  upper_mask;

  logic               hi_hit;
  logic [IDX_LEN-1:0] hi_idx;
  logic [NR_REQ-1:0]  hi_onehot;
  logic               all_hit;
  logic [IDX_LEN-1:0] all_idx;
  logic [NR_REQ-1:0]  all_onehot;

  logic               sel_hit;
  logic [IDX_LEN-1:0] sel_idx;
  logic [NR_REQ-1:0]  sel_onehot;

  // The bit being handed over this cycle is dropped from the eligible set so
  // the concurrent reload cannot grant the same request twice.
  always_comb begin
    handshake = (state == FULL) && bus.out_ready;
    load      = (state == EMPTY) || handshake;
    eligible  = bus.req & ~(handshake ? onehot_q : '0);
    upper_mask = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      upper_mask[i] = (IDX_LEN'(i) >= ptr);
    end
  end

  // Double scan: requests at or above the pointer first, then the whole
  // vector, which gives the wrap-around ptr..NR_REQ-1, 0..ptr-1.
  ysyx_22050243_prienc #(
    .NR_REQ  (NR_REQ),
    .IDX_LEN (IDX_LEN)
  ) u_scan_hi (
    .req    (eligible & upper_mask),
    .hit    (hi_hit),
    .idx    (hi_idx),
    .onehot (hi_onehot)
  );

  ysyx_22050243_prienc #(
    .NR_REQ  (NR_REQ),
    .IDX_LEN (IDX_LEN)
  ) u_scan_all (
    .req    (eligible),
    .hit    (all_hit),
    .idx    (all_idx),
    .onehot (all_onehot)
  );

  always_comb begin
    sel_hit    = hi_hit | all_hit;
    sel_idx    = hi_hit ? hi_idx    : all_idx;
    sel_onehot = hi_hit ? hi_onehot : all_onehot;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // FSM next state: a load decides FULL/EMPTY, otherwise the state holds.
  always_comb begin
    state_next = state;
    if (load) begin
      state_next = sel_hit ? FULL : EMPTY;
    end
  end

  // FSM outputs: the grant is driven straight from registers.
  always_comb begin
    bus.out_valid  = (state == FULL);
    bus.out_idx    = idx_q;
    bus.out_onehot = onehot_q;
  end

  // Grant registers and rotating pointer. Without a load the grant is frozen;
  // an empty load clears it so out_onehot is zero whenever out_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= '0;
      onehot_q <= '0;
      ptr      <= '0;
    end else begin
      if (load) begin
        idx_q    <= sel_hit ? sel_idx    : '0;
        onehot_q <= sel_hit ? sel_onehot : '0;
      end
      if (handshake) begin
        ptr <= (idx_q == IDX_LEN'(NR_REQ - 1)) ? '0 : idx_q + IDX_LEN'(1);
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050243_rr_encoder.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22050243_rr_encoder
// Self-checking bench: an 8-requester and a 5-requester encoder, a vector
// table for the 8-wide instance, a hand sequence for the 5-wide wrap, and a
// random phase compared against a scan-based reference model.
// ---------------------------------------------------------------------------
module tb_ysyx_22050243_rr_encoder;

  logic clk = 1'b0;
  logic rst8;
  logic rst5;

  always #5 clk = ~clk;

  ysyx_22050243_rr_encoder_if #(.NR_REQ(8), .IDX_LEN(3)) bus8 ();
  ysyx_22050243_rr_encoder_if #(.NR_REQ(5), .IDX_LEN(3)) bus5 ();

  ysyx_22050243_rr_encoder #(.NR_REQ(8), .IDX_LEN(3)) dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (bus8.slave)
  );

  ysyx_22050243_rr_encoder #(.NR_REQ(5), .IDX_LEN(3)) dut5 (
    .clk (clk),
    .rst (rst5),
    .bus (bus5.slave)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          rst;
    logic [7:0]  req;
    bit          rdy;
    bit          exp_valid;
    int          exp_idx;
    logic [7:0]  exp_onehot;
    string       name;
  } vec_t;

  vec_t tbl[$];

  // Reference model state for each instance.
  bit m8_v;
  int m8_idx;
  int m8_ptr;
  bit m5_v;
  int m5_idx;
  int m5_ptr;

  // Reference model: on a load, walk k=0..n-1 from the pointer modulo n and
  // take the first eligible request.
  function automatic void model_step(input int n, input bit r, input logic [7:0] rq,
                                     input bit rdy, inout bit v, inout int idx,
                                     inout int ptr);
    bit         hs;
    logic [7:0] elig;
    int         nptr;
    bit         found;
    if (r) begin
      v   = 1'b0;
      idx = 0;
      ptr = 0;
      return;
    end
    hs = v && rdy;
    if (!v || hs) begin
      elig = rq;
      if (hs) elig[idx] = 1'b0;
      nptr = hs ? (idx + 1) % n : ptr;
      found = 1'b0;
      for (int k = 0; k < n; k++) begin
        int j;
        j = (ptr + k) % n;
        if (!found && elig[j]) begin
          found = 1'b1;
          idx   = j;
        end
      end
      v   = found;
      ptr = nptr;
    end
  endfunction

  function automatic logic [7:0] onehot_of(input bit v, input int idx);
    logic [7:0] o;
    o = 8'h00;
    if (v) o[idx] = 1'b1;
    return o;
  endfunction

  task automatic addVec(input bit r, input logic [7:0] rq, input bit rdy, input bit ev,
                        input int ei, input logic [7:0] eo, input string nm);
    vec_t t;
    t.rst = r; t.req = rq; t.rdy = rdy;
    t.exp_valid = ev; t.exp_idx = ei; t.exp_onehot = eo; t.name = nm;
    tbl.push_back(t);
  endtask

  // Drive both instances, then sample 1 time unit after the rising edge.
  task automatic applyStimulus(input bit r8, input logic [7:0] rq8, input bit rdy8,
                               input bit r5, input logic [4:0] rq5, input bit rdy5);
    rst8 = r8;
    bus8.req = rq8;
    bus8.out_ready = rdy8;
    rst5 = r5;
    bus5.req = rq5;
    bus5.out_ready = rdy5;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string nm, input logic v_act, input logic [2:0] i_act,
                             input logic [7:0] o_act, input bit v_exp, input int i_exp,
                             input logic [7:0] o_exp, input bit idx_care);
    logic [2:0] i_exp3;
    i_exp3 = 3'(i_exp);
    checks++;
    if (v_act !== v_exp) begin
      errors++;
      $display("[TB] FAIL %s out_valid: got %0b want %0b", nm, v_act, v_exp);
    end
    checks++;
    if (o_act !== o_exp) begin
      errors++;
      $display("[TB] FAIL %s out_onehot: got %02h want %02h", nm, o_act, o_exp);
    end
    if (idx_care) begin
      checks++;
      if (i_act !== i_exp3) begin
        errors++;
        $display("[TB] FAIL %s out_idx: got %0d want %0d", nm, i_act, i_exp3);
      end
    end
  endtask

  initial begin
    rst8 = 1'b1; rst5 = 1'b1;
    bus8.req = '0; bus8.out_ready = 1'b0;
    bus5.req = '0; bus5.out_ready = 1'b0;

    // Vector table for the 8-requester instance (expected = after the edge).
    addVec(1, 8'hFF, 1, 0, 0, 8'h00, "reset0");
    addVec(1, 8'hFF, 1, 0, 0, 8'h00, "reset1");
    addVec(1, 8'hFF, 1, 0, 0, 8'h00, "reset2");
    addVec(0, 8'hFF, 0, 1, 0, 8'h01, "first_grant");
    addVec(0, 8'hFF, 1, 1, 1, 8'h02, "hs_then_1");
    addVec(0, 8'h00, 1, 0, 0, 8'h00, "drain");
    addVec(0, 8'h20, 1, 1, 5, 8'h20, "single_5");
    addVec(0, 8'h20, 1, 0, 0, 8'h00, "single_masked");
    addVec(0, 8'hFF, 0, 1, 6, 8'h40, "after_5_is_6");
    addVec(0, 8'h00, 1, 0, 0, 8'h00, "drain2");
    addVec(1, 8'h81, 1, 0, 0, 8'h00, "reset_again");
    addVec(0, 8'h81, 1, 1, 0, 8'h01, "fair_0a");
    addVec(0, 8'h81, 1, 1, 7, 8'h80, "fair_7a");
    addVec(0, 8'h81, 1, 1, 0, 8'h01, "fair_0b");
    addVec(0, 8'h81, 1, 1, 7, 8'h80, "fair_7b");
    addVec(0, 8'h81, 1, 1, 0, 8'h01, "fair_0c");
    addVec(0, 8'h00, 1, 0, 0, 8'h00, "drain3");
    addVec(0, 8'h08, 0, 1, 3, 8'h08, "bp_load3");
    for (int i = 0; i < 5; i++) addVec(0, 8'h40, 0, 1, 3, 8'h08, "bp_hold");
    addVec(0, 8'h40, 1, 1, 6, 8'h40, "bp_release_6");
    addVec(0, 8'h00, 1, 0, 0, 8'h00, "drain4");
    addVec(0, 8'h02, 1, 1, 1, 8'h02, "prep_1");
    addVec(0, 8'h00, 1, 0, 0, 8'h00, "prep_ptr2");
    addVec(0, 8'h40, 0, 1, 6, 8'h40, "full_6_ptr2");
    addVec(1, 8'hC0, 1, 0, 0, 8'h00, "mid_reset");
    addVec(0, 8'hC0, 0, 1, 6, 8'h40, "post_reset_6");
    addVec(0, 8'hC0, 1, 1, 7, 8'h80, "post_reset_7");
    addVec(0, 8'h00, 1, 0, 0, 8'h00, "drain5");

    foreach (tbl[n]) begin
      applyStimulus(tbl[n].rst, tbl[n].req, tbl[n].rdy, 1'b1, 5'h00, 1'b0);
      checkOutput(tbl[n].name, bus8.out_valid, bus8.out_idx, bus8.out_onehot,
                  tbl[n].exp_valid, tbl[n].exp_idx, tbl[n].exp_onehot,
                  tbl[n].exp_valid || tbl[n].rst);
    end

    // Non-power-of-two wrap on the 5-requester instance.
    applyStimulus(1, 8'h00, 0, 0, 5'b10001, 0);
    checkOutput("w5_first0", bus5.out_valid, bus5.out_idx, {3'b000, bus5.out_onehot},
                1, 0, 8'h01, 1);
    applyStimulus(1, 8'h00, 0, 0, 5'b10001, 1);
    checkOutput("w5_grant4", bus5.out_valid, bus5.out_idx, {3'b000, bus5.out_onehot},
                1, 4, 8'h10, 1);
    applyStimulus(1, 8'h00, 0, 0, 5'b10001, 1);
    checkOutput("w5_wrap0", bus5.out_valid, bus5.out_idx, {3'b000, bus5.out_onehot},
                1, 0, 8'h01, 1);
    applyStimulus(1, 8'h00, 0, 0, 5'b10000, 1);
    checkOutput("w5_again4", bus5.out_valid, bus5.out_idx, {3'b000, bus5.out_onehot},
                1, 4, 8'h10, 1);
    applyStimulus(1, 8'h00, 0, 0, 5'b00001, 1);
    checkOutput("w5_again0", bus5.out_valid, bus5.out_idx, {3'b000, bus5.out_onehot},
                1, 0, 8'h01, 1);

    // Random phase against the reference model, both instances at once.
    m8_v = 0; m8_idx = 0; m8_ptr = 0;
    m5_v = 0; m5_idx = 0; m5_ptr = 0;
    for (int c = 0; c < 600; c++) begin
      bit         r8, r5, y8, y5;
      logic [7:0] q8;
      logic [4:0] q5;
      r8 = (c == 0) || ($urandom_range(0, 40) == 0);
      r5 = (c == 0) || ($urandom_range(0, 40) == 0);
      y8 = ($urandom_range(0, 3) != 0);
      y5 = ($urandom_range(0, 3) != 0);
      q8 = 8'($urandom) & 8'($urandom);
      q5 = 5'($urandom);
      model_step(8, r8, q8, y8, m8_v, m8_idx, m8_ptr);
      model_step(5, r5, {3'b000, q5}, y5, m5_v, m5_idx, m5_ptr);
      applyStimulus(r8, q8, y8, r5, q5, y5);
      checkOutput("rand8", bus8.out_valid, bus8.out_idx, bus8.out_onehot,
                  m8_v, m8_idx, onehot_of(m8_v, m8_idx), m8_v || r8);
      checkOutput("rand5", bus5.out_valid, bus5.out_idx, {3'b000, bus5.out_onehot},
                  m5_v, m5_idx, onehot_of(m5_v, m5_idx), m5_v || r5);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22050243_rr_encoder.md
# ysyx_22050243_rr_encoder

Registered round-robin priority encoder: the inverse of the one-hot decoders. It converts an N-bit request vector into one binary index plus its one-hot grant, and presents the result through a valid/ready handshake. It sits between multiple requesters (e.g. interrupt sources, bus masters, writeback ports) and a single consumer. A rotating pointer guarantees fairness.

## Interface
- `NR_REQ`, default 8: number of request lines, ≥2; need not be a power of two.
- `IDX_LEN`, default 3: index width, must equal clog2(`NR_REQ`).
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset. One clock; reset is synchronous and active-high.
- `req` input `NR_REQ`: level request vector, bit i = requester i pending.
- `out_ready` input 1: consumer accepts the current output.
- `out_valid` output 1: `out_idx`/`out_onehot` hold a pending grant.
- `out_idx` output `IDX_LEN`: binary index of the granted requester.
- `out_onehot` output `NR_REQ`: one-hot of `out_idx`. All zero when `out_valid`=0.

## Operation
- The FSM has two states: EMPTY (`out_valid`=0) and FULL (`out_valid`=1). Handshake = `out_valid && out_ready`.
- Selection scans `req` starting at pointer `ptr`: ptr, ptr+1, …, `NR_REQ`-1, 0, …, ptr-1. The first set bit wins. Wrap is at `NR_REQ`, not at 2^`IDX_LEN`.
- Load condition: state EMPTY, or a handshake this cycle. On load:
  - If any eligible bit is set, register idx/onehot and go (or stay) FULL.
  - Otherwise go EMPTY.
- Masking: on a handshake cycle, the bit being granted is removed from the eligible set for the concurrent load. The requester clears its line from the cycle after the handshake, so the same request is never granted twice.
- Pointer: reset value 0. On each handshake with index k, `ptr` ← (k+1) mod `NR_REQ`. It is unchanged otherwise.
- While FULL without a handshake, `out_idx`/`out_onehot` are frozen, even if `req` changes or the granted bit drops. There is no retraction.
- `out_idx` and `out_onehot` are always registered together and are always consistent.

## Timing
- Reset: `out_valid`=0, `out_idx`=0, `out_onehot`=0, `ptr`=0, state EMPTY. These hold for every cycle `rst` is sampled high, regardless of `req`/`out_ready`.
- Reset mid-operation: a pending grant is dropped. It does not count as a handshake, and the pointer returns to 0.
- Latency: `req` sampled at edge t leads to `out_valid` at t+1 (one cycle, registered).
- Throughput: one grant per cycle when `out_ready`=1 and eligible requests exist.
- `out_valid` falls only on a handshake with no eligible request, or on reset.
- `out_ready` may be asserted while `out_valid`=0. It has no effect in that case.
- Outputs have no combinational path from `req` or `out_ready`.

## Structure
- Shared constants header:
  - default `NR_REQ`/`IDX_LEN`
  - state encodings EMPTY=1'b0, FULL=1'b1
- Sub-module `ysyx_22050243_prienc` #(`NR_REQ`, `IDX_LEN`): combinational fixed-priority (lowest index wins) encoder producing `hit`, `idx`, `onehot`.
- The top instantiates two copies for the double-scan round-robin:
  - Copy 1 sees eligible requests with index ≥ ptr.
  - Copy 2 sees all eligible requests.
  - Copy 1's result is used if its `hit` is set, otherwise copy 2's.
- Pointer, state and output registers live in the top. Expected size is about 150–250 lines total.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `req`=8'hFF and `out_ready`=1.
  - Required: `out_valid`=0, `out_idx`=0, `out_onehot`=0 throughout.
  - After release: first grant at idx 0 one cycle later.
- Single request: `req`=8'h20 and `out_ready`=1 at cycle 1; requester clears on handshake.
  - Cycle 2: `out_valid`=1, `out_idx`=5, `out_onehot`=8'h20.
  - Cycle 3: `out_valid`=0. Next grant for `req`=8'hFF is idx 6.
- Fairness: `req`=8'h81 held constant, `out_ready`=1.
  - Grant sequence is 0,7,0,7,… on consecutive cycles. There is no idle cycle and no repeated index.
- Backpressure: FULL with idx 3, `out_ready`=0 for 5 cycles while `req` changes to 8'h40.
  - Output stays idx 3 / 8'h08.
  - Raise `out_ready`: handshake, then next grant is idx 6.
- Non-power-of-two wrap: `NR_REQ`=5, `IDX_LEN`=3, `req`=5'b10001.
  - After a grant of 4, `ptr`=0 and the next grant is 0, not an out-of-range index.
- Reset mid-grant: FULL with idx 6, `ptr`=2; assert `rst` for 1 cycle with `req`=8'hC0.
  - Required: `out_valid`=0 during reset.
  - Then a grant of idx 6 (scan from 0), proving the pointer was reset.
